// File: rtl/floo_eject_err_sink_if.sv
// Narrow request/response and wide flit handshakes between a router Eject port
// and the error sink that terminates it on a dummy tile.
interface floo_eject_err_sink_if #(
  parameter int unsigned AxiIdWidth  = 6,
  parameter int unsigned NodeIdWidth = 8,
  parameter int unsigned LenWidth    = 8
);
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [1:0]             req_type_i;
  logic [AxiIdWidth-1:0]  req_axi_id_i;
  logic [LenWidth-1:0]    req_len_i;
  logic                   req_last_i;
  logic [NodeIdWidth-1:0] req_src_id_i;

  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic                   rsp_type_o;
  logic [AxiIdWidth-1:0]  rsp_axi_id_o;
  logic [1:0]             rsp_resp_o;
  logic                   rsp_last_o;
  logic [NodeIdWidth-1:0] rsp_dst_id_o;

  logic                   wide_valid_i;
  logic                   wide_ready_o;

  // Router side.
  modport master (
    output req_valid_i, req_type_i, req_axi_id_i, req_len_i, req_last_i, req_src_id_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_type_o, rsp_axi_id_o, rsp_resp_o, rsp_last_o, rsp_dst_id_o,
    output rsp_ready_i,
    output wide_valid_i,
    input  wide_ready_o
  );

  // Error sink side.
  modport slave (
    input  req_valid_i, req_type_i, req_axi_id_i, req_len_i, req_last_i, req_src_id_i,
    output req_ready_o,
    output rsp_valid_o, rsp_type_o, rsp_axi_id_o, rsp_resp_o, rsp_last_o, rsp_dst_id_o,
    input  rsp_ready_i,
    input  wide_valid_i,
    output wide_ready_o
  );
endinterface

// File: rtl/floo_eject_err_sink.sv
// Eject-port terminator for a dummy tile: answers every narrow AXI request with
// DECERR, swallows wide flits, and keeps saturating diagnostic event counters.
module floo_eject_err_sink #(
  parameter int unsigned AxiIdWidth  = 6,
  parameter int unsigned NodeIdWidth = 8,
  parameter int unsigned LenWidth    = 8,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  floo_eject_err_sink_if.slave bus,
  output logic [CntWidth-1:0] wr_err_cnt_o,
  output logic [CntWidth-1:0] rd_err_cnt_o,
  output logic [CntWidth-1:0] drop_cnt_o
);

  typedef enum logic [1:0] {REQ_AW = 2'd0, REQ_W = 2'd1, REQ_AR = 2'd2, REQ_RSVD = 2'd3} req_type_e;
  typedef enum logic [1:0] {IDLE, W_DRAIN, B_RSP, R_RSP} state_e;

  localparam logic [1:0] RespDecErr = 2'b11;

  state_e                 state_q, state_d;
  logic [AxiIdWidth-1:0]  id_q;
  logic [NodeIdWidth-1:0] src_q;
  logic [LenWidth-1:0]    len_q;
  logic [LenWidth-1:0]    beat_q;

  logic req_hs, rsp_hs, last_beat;
  logic narrow_drop, wr_done, rd_done;
  logic [1:0] drop_inc;

  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] cnt,
                                                   input logic [1:0]          inc);
    logic [CntWidth:0] sum;
    sum = {1'b0, cnt} + {{(CntWidth-1){1'b0}}, inc};
    return sum[CntWidth] ? {CntWidth{1'b1}} : sum[CntWidth-1:0];
  endfunction

  assign req_hs    = bus.req_valid_i & bus.req_ready_o;
  assign rsp_hs    = bus.rsp_valid_o & bus.rsp_ready_i;
  assign last_beat = (beat_q == len_q);

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: next-state defaults to the current state before the case so no
  // path leaves state_d unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_hs && bus.req_type_i == REQ_AW) state_d = W_DRAIN;
        if (req_hs && bus.req_type_i == REQ_AR) state_d = R_RSP;
      end
      W_DRAIN: if (req_hs && bus.req_last_i) state_d = B_RSP;
      B_RSP:   if (rsp_hs)                   state_d = IDLE;
      R_RSP:   if (rsp_hs && last_beat)      state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // Response fields decode only registered state, so req_* never reaches rsp_*.
  always_comb begin
    bus.req_ready_o  = 1'b0;
    bus.rsp_valid_o  = 1'b0;
    bus.rsp_type_o   = 1'b0;
    bus.rsp_last_o   = 1'b0;
    unique case (state_q)
      IDLE:    bus.req_ready_o = 1'b1;
      W_DRAIN: bus.req_ready_o = (bus.req_type_i == REQ_W);
      B_RSP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_last_o  = 1'b1;
      end
      R_RSP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_type_o  = 1'b1;
        bus.rsp_last_o  = last_beat;
      end
      default: ;
    endcase
  end

  assign bus.rsp_axi_id_o = id_q;
  assign bus.rsp_dst_id_o = src_q;
  assign bus.rsp_resp_o   = RespDecErr;
  assign bus.wide_ready_o = 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q   <= '0;
      src_q  <= '0;
      len_q  <= '0;
      beat_q <= '0;
    end else if (state_q == IDLE && req_hs &&
                 (bus.req_type_i == REQ_AW || bus.req_type_i == REQ_AR)) begin
      id_q  <= bus.req_axi_id_i;
      src_q <= bus.req_src_id_i;
      if (bus.req_type_i == REQ_AR) begin
        len_q  <= bus.req_len_i;
        beat_q <= '0;
      end
    end else if (state_q == R_RSP && rsp_hs) begin
      beat_q <= beat_q + 1'b1;
    end
  end

  assign narrow_drop = (state_q == IDLE) && req_hs &&
                       (bus.req_type_i == REQ_W || bus.req_type_i == REQ_RSVD);
  assign drop_inc    = {1'b0, narrow_drop} + {1'b0, bus.wide_valid_i};
  assign wr_done     = (state_q == B_RSP) && rsp_hs;
  assign rd_done     = (state_q == R_RSP) && rsp_hs && last_beat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_err_cnt_o <= '0;
      rd_err_cnt_o <= '0;
      drop_cnt_o   <= '0;
    end else begin
      if (wr_done)          wr_err_cnt_o <= sat_add(wr_err_cnt_o, 2'd1);
      if (rd_done)          rd_err_cnt_o <= sat_add(rd_err_cnt_o, 2'd1);
      if (drop_inc != 2'd0) drop_cnt_o   <= sat_add(drop_cnt_o, drop_inc);
    end
  end

endmodule

// File: tb/tb_floo_eject_err_sink.sv
// Scoreboard bench for floo_eject_err_sink: stimulus queues expected DECERR
// flits and counter values; a negedge monitor compares every response handshake.
module tb_floo_eject_err_sink;
  localparam int ID_W    = 6;
  localparam int NODE_W  = 8;
  localparam int LEN_W   = 8;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              is_r;
    logic [ID_W-1:0]   id;
    logic              last;
    logic [NODE_W-1:0] dst;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  floo_eject_err_sink_if #(.AxiIdWidth(ID_W), .NodeIdWidth(NODE_W), .LenWidth(LEN_W)) bus ();

  logic [CNT_W-1:0] wr_cnt, rd_cnt, drop_cnt;

  floo_eject_err_sink #(
    .AxiIdWidth(ID_W), .NodeIdWidth(NODE_W), .LenWidth(LEN_W), .CntWidth(CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus),
    .wr_err_cnt_o (wr_cnt),
    .rd_err_cnt_o (rd_cnt),
    .drop_cnt_o   (drop_cnt)
  );

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  int   exp_wr = 0, exp_rd = 0, exp_drop = 0;
  bit   in_wr = 0;
  logic [ID_W-1:0]   aw_id;
  logic [NODE_W-1:0] aw_src;
  int   rsp_mode = 0;   // 0 always ready, 1 toggle, 2 never, 3 random
  bit   wide_rand = 0;
  bit   wide_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Response-ready and wide-valid generators.
  always @(posedge clk) begin
    #1;
    case (rsp_mode)
      0:       bus.rsp_ready_i = 1'b1;
      1:       bus.rsp_ready_i = ~bus.rsp_ready_i;
      2:       bus.rsp_ready_i = 1'b0;
      default: bus.rsp_ready_i = 1'($urandom_range(0, 1));
    endcase
    if (wide_q.size() > 0) bus.wide_valid_i = wide_q.pop_front();
    else if (wide_rand)    bus.wide_valid_i = ($urandom_range(0, 2) == 0);
    else                   bus.wide_valid_i = 1'b0;
  end

  // Monitor: wide drops, response stability while stalled, scoreboard compare.
  rsp_t       prev_flit;
  logic [1:0] prev_resp;
  bit         prev_stall = 0;
  always @(negedge clk) begin
    rsp_t cur;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (bus.wide_valid_i) begin
        check("wide_ready", 64'(bus.wide_ready_o), 64'd1);
        if (bus.wide_ready_o) exp_drop = sat(exp_drop + 1);
      end
      cur = '{is_r: bus.rsp_type_o, id: bus.rsp_axi_id_o, last: bus.rsp_last_o, dst: bus.rsp_dst_id_o};
      if (prev_stall)
        check("rsp_stable", 64'({bus.rsp_valid_o, bus.rsp_resp_o, cur}), 64'({1'b1, prev_resp, prev_flit}));
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("rsp_flit", 64'(cur), 64'(exp_q.pop_front()));
        check("rsp_resp", 64'(bus.rsp_resp_o), 64'd3);
      end
      prev_stall = bus.rsp_valid_o && !bus.rsp_ready_i;
      prev_flit  = cur;
      prev_resp  = bus.rsp_resp_o;
    end
  end

  // Issue one request flit, wait for acceptance, and update the reference model.
  task automatic send_req(input logic [1:0] t, input logic [ID_W-1:0] id,
                          input logic [LEN_W-1:0] len, input logic last,
                          input logic [NODE_W-1:0] src);
    bit   got = 0;
    int   n = 0;
    bit   expect_rsp = 0;
    logic exp_type = 1'b0;
    bus.req_valid_i  = 1'b1;
    bus.req_type_i   = t;
    bus.req_axi_id_i = id;
    bus.req_len_i    = len;
    bus.req_last_i   = last;
    bus.req_src_id_i = src;
    while (!got && n < 600) begin
      @(negedge clk);
      got = bus.req_ready_o;
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid_i = 1'b0;
    check("req_accept", 64'(got), 64'd1);
    if (!got) return;
    case (t)
      2'd0: begin in_wr = 1; aw_id = id; aw_src = src; end
      2'd1: begin
        if (!in_wr) exp_drop = sat(exp_drop + 1);
        else if (last) begin
          exp_q.push_back('{is_r: 1'b0, id: aw_id, last: 1'b1, dst: aw_src});
          in_wr = 0;
          exp_wr = sat(exp_wr + 1);
          expect_rsp = 1;
        end
      end
      2'd2: begin
        for (int b = 0; b <= int'(len); b++)
          exp_q.push_back('{is_r: 1'b1, id: id, last: (b == int'(len)), dst: src});
        exp_rd = sat(exp_rd + 1);
        expect_rsp = 1;
        exp_type = 1'b1;
      end
      default: exp_drop = sat(exp_drop + 1);
    endcase
    if (expect_rsp)
      check("rsp_next_cycle", 64'({bus.rsp_valid_o, bus.rsp_type_o}), 64'({1'b1, exp_type}));
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_counters(input string tag);
    @(posedge clk); #1;
    check({tag, "_wr_cnt"},   64'(wr_cnt),   64'(exp_wr));
    check({tag, "_rd_cnt"},   64'(rd_cnt),   64'(exp_rd));
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic hold_ar_check(input string name, input int cycles);
    bus.req_valid_i  = 1'b1;
    bus.req_type_i   = 2'd2;
    bus.req_axi_id_i = 6'h2A;
    bus.req_len_i    = 8'd0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(name, 64'(bus.req_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    bus.req_valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.req_valid_i  = 1'b0;
    bus.req_type_i   = 2'd0;
    bus.req_axi_id_i = '0;
    bus.req_len_i    = '0;
    bus.req_last_i   = 1'b0;
    bus.req_src_id_i = '0;
    bus.rsp_ready_i  = 1'b1;
    bus.wide_valid_i = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid",  64'(bus.rsp_valid_o),  64'd0);
    check("reset_req_ready",  64'(bus.req_ready_o),  64'd1);
    check("reset_wide_ready", 64'(bus.wide_ready_o), 64'd1);
    check("reset_counters",   64'({wr_cnt, rd_cnt, drop_cnt}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // AR id=5 len=3: four consecutive R beats.
    send_req(2'd2, 6'd5, 8'd3, 1'b0, 8'h12);
    wait_drain(c);
    check("ar4_cycles", 64'(c), 64'd4);
    check_counters("ar4");

    // AW id=9 plus four W beats: single B.
    send_req(2'd0, 6'd9, 8'd0, 1'b0, 8'h34);
    for (int i = 0; i < 4; i++) send_req(2'd1, 6'd0, 8'd0, (i == 3), 8'h00);
    wait_drain(c);
    check("b_cycles", 64'(c), 64'd1);
    check_counters("aw");

    // Three stray W and five wide flits, two of them in the same cycle.
    for (int i = 0; i < 5; i++) wide_q.push_back(1'b1);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      bus.req_valid_i = (cyc == 1 || cyc == 2 || cyc == 7);
      bus.req_type_i  = 2'd1;
      bus.req_last_i  = 1'b0;
      @(negedge clk);
      if (bus.req_valid_i) begin
        check("stray_w_ready", 64'(bus.req_ready_o), 64'd1);
        exp_drop = sat(exp_drop + 1);
      end
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check("drop_eight", 64'(drop_cnt), 64'd8);
    check_counters("drop");

    // AR len=1 against a toggling rsp_ready.
    rsp_mode = 1;
    send_req(2'd2, 6'h21, 8'd1, 1'b0, 8'h56);
    wait_drain(c);
    rsp_mode = 0;
    repeat (3) begin
      @(negedge clk);
      check("no_extra_rsp", 64'(bus.rsp_valid_o), 64'd0);
    end
    check_counters("stall");

    // AR held off during W_DRAIN and B_RSP, then answered after B.
    rsp_mode = 2;
    send_req(2'd0, 6'h0A, 8'd0, 1'b0, 8'h77);
    send_req(2'd1, 6'd0, 8'd0, 1'b0, 8'h00);
    hold_ar_check("ar_blocked_wdrain", 3);
    send_req(2'd1, 6'd0, 8'd0, 1'b1, 8'h00);
    hold_ar_check("ar_blocked_brsp", 3);
    rsp_mode = 0;
    send_req(2'd2, 6'h03, 8'd2, 1'b0, 8'h77);
    wait_drain(c);
    check_counters("order");

    // Longest burst: len=255 gives 256 beats.
    send_req(2'd2, 6'h3F, 8'd255, 1'b0, 8'hFF);
    wait_drain(c);
    check("ar256_cycles", 64'(c), 64'd256);
    check_counters("ar256");

    // Asynchronous reset while beat 2 of 4 is presented.
    send_req(2'd2, 6'd7, 8'd3, 1'b0, 8'h44);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("midreset_counters",  64'({wr_cnt, rd_cnt, drop_cnt}), 64'd0);
    exp_q.delete();
    exp_wr = 0; exp_rd = 0; exp_drop = 0; in_wr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_req(2'd2, 6'h11, 8'd2, 1'b0, 8'h99);
    wait_drain(c);
    check_counters("postreset");

    // Randomized traffic; counters are expected to saturate along the way.
    wide_rand = 1;
    rsp_mode  = 3;
    for (int op = 0; op < 120; op++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        send_req(2'd2, 6'($urandom), 8'($urandom_range(0, 5)), 1'b0, 8'($urandom));
      end else if (kind <= 6) begin
        int beats;
        beats = $urandom_range(1, 4);
        send_req(2'd0, 6'($urandom), 8'($urandom), 1'b0, 8'($urandom));
        for (int i = 0; i < beats; i++) send_req(2'd1, 6'($urandom), 8'($urandom), (i == beats - 1), 8'($urandom));
      end else if (kind == 7) begin
        send_req(2'd1, 6'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
      end else if (kind == 8) begin
        send_req(2'd3, 6'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
      end else begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wide_rand = 0;
    rsp_mode  = 0;
    wait_drain(c);
    repeat (3) @(posedge clk);
    #1;
    check_counters("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
